uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a parallel byte and holds it for the serializer. It enables the serializer for exactly Data_Width bit-times and muxes start, data, parity and stop bits onto the TX line. It sits between the host-side data interface and the serializer/counter datapath, one bit per clk.

Parameters:
Data_Width, 8, number of data bits per frame (LSB first); serializer and bit counter sized to match
Cnt_Width, 3, width of internal data-bit counter; must satisfy 2**Cnt_Width >= Data_Width

Ports:
clk  input  1  transmit bit clock, one UART bit per cycle
RST  input  1  asynchronous active-low reset
P_Data  input  Data_Width  parallel data from host, sampled on accept
Data_Valid  input  1  host request; sampled every cycle
Par_En  input  1  1 = insert parity bit; sampled on accept
Par_Typ  input  1  0 = even, 1 = odd parity; sampled on accept
Ser_Data  input  1  serial bit from serializer
Ser_Done  input  1  serializer last-bit flag
Ser_En  output  1  serializer enable; low holds serializer counter in reset
P_Data_Hold  output  Data_Width  latched frame data driven to serializer
TX_OUT  output  1  UART line
Ready  output  1  new frame may be accepted this cycle
Busy  output  1  frame in progress
Frame_Err  output  1  sticky serializer/controller mismatch flag

Behaviour:
- Reset (RST low, async): state IDLE, P_Data_Hold=0, latched Par_En/Par_Typ=0, bit counter=0, Frame_Err=0. Outputs: TX_OUT=1, Ser_En=0, Busy=0, Ready=1.
- States: IDLE, START, DATA, PARITY, STOP. State, counter, hold regs and Frame_Err are registers. Outputs are decoded from state (Moore), except TX_OUT in DATA, which passes Ser_Data straight through.
- Accept: rising edge with Data_Valid=1 and state in {IDLE, STOP}. Latches P_Data, Par_En, Par_Typ and clears Frame_Err. Next state START. Data_Valid at any other time is ignored; the host holds it until Ready.
- Ready = state IDLE or STOP. Busy = state != IDLE.
- IDLE: TX_OUT=1. Go to START on accept, else stay.
- START: TX_OUT=0, one cycle. Next DATA, counter=0.
- DATA: Ser_En=1, TX_OUT=Ser_Data. Counter increments each cycle.
  - When counter==Data_Width-1, next state is PARITY if latched Par_En, else STOP. The counter then clears.
  - The controller's counter is authoritative; Ser_Done does not change state.
- Serializer check: Frame_Err is set at the clock edge if, in DATA, Ser_Done=1 with counter != Data_Width-1, or Ser_Done=0 with counter == Data_Width-1. It stays set until the next accept or reset.
- PARITY: TX_OUT = XOR of all P_Data_Hold bits, XOR latched Par_Typ. One cycle, then STOP.
- STOP: TX_OUT=1, one cycle. Go to START on accept (back-to-back, no idle gap), else IDLE.
- Frame length from START through STOP: Data_Width+3 cycles with parity, Data_Width+2 without.
- Ser_En is low outside DATA, so the serializer counter restarts at 0 for every frame.
- P_Data_Hold, Par_En and Par_Typ are stable from START through STOP. Host changes to P_Data after accept have no effect.
- Reset mid-frame: immediate return to IDLE with TX_OUT=1; the partial frame is abandoned and no Frame_Err is raised.
- Data_Valid in START/DATA/PARITY: ignored, no latch, frame unaffected.

Test Plan:
- Reset values: hold RST=0 → TX_OUT=1, Ser_En=0, Busy=0, Ready=1, Frame_Err=0. Release and idle 5 cycles → TX_OUT stays 1.
- Even parity, P_Data=0xA5, Par_En=1, Par_Typ=0, pulse Data_Valid at t0 → TX_OUT from t1: 0, 1,0,1,0,0,1,0,1, 0, 1. Ser_En high t2..t9 only. Busy low at t12.
- Odd parity, P_Data=0x01 with Par_Typ=1 → parity bit 0. Repeat with Par_Typ=0 → parity bit 1. Par_En=0 → 10-cycle frame, no parity slot.
- Back-to-back: Data_Valid held high with 0x3C then 0xC3 → second START immediately follows first STOP, no idle cycle. Data_Valid during DATA does not corrupt the first frame.
- Serializer fault: Ser_Done forced high at counter=3 → Frame_Err=1 after that edge. Frame still completes in 11 cycles. Frame_Err cleared at next accept.
- Async reset asserted mid-DATA (counter=4) → TX_OUT=1, state IDLE, Ser_En=0 without waiting for a clk edge. The next accept sends a full clean frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART frame sequencer muxing start, data, parity and stop bits onto TX_OUT
module uart_tx_ctrl #(
  parameter int Data_Width = 8,
  parameter int Cnt_Width  = 3
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [Data_Width-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic                  Ser_Data,
  input  logic                  Ser_Done,
  output logic                  Ser_En,
  output logic [Data_Width-1:0] P_Data_Hold,
  output logic                  TX_OUT,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Frame_Err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                r_state, w_next;
  logic [Cnt_Width-1:0]  r_cnt;
  logic [Data_Width-1:0] r_hold;
  logic                  r_par_en, r_par_typ, r_frame_err;
  logic                  w_accept, w_last, w_parity, w_tx;
  assign w_accept = Data_Valid && (r_state == IDLE || r_state == STOP);
  assign w_last   = r_cnt == Cnt_Width'(Data_Width - 1);
  assign w_parity = ^r_hold ^ r_par_typ;
  // The local counter decides when DATA ends; Ser_Done is only cross-checked against it.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_par_en    <= 1'b0;
      r_par_typ   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (r_state == DATA && !w_last) ? r_cnt + Cnt_Width'(1) : '0;
      r_frame_err <= w_accept ? 1'b0 :
                     (r_state == DATA && (Ser_Done != w_last)) ? 1'b1 : r_frame_err;
      if (w_accept) begin
        r_hold    <= P_Data;
        r_par_en  <= Par_En;
        r_par_typ <= Par_Typ;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    case (r_state)
      IDLE:    w_next = w_accept ? START : IDLE;
      START:   begin w_next = DATA; w_tx = 1'b0; end
      DATA:    begin w_tx = Ser_Data; if (w_last) w_next = r_par_en ? PARITY : STOP; end
      PARITY:  begin w_next = STOP; w_tx = w_parity; end
      STOP:    w_next = w_accept ? START : IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign TX_OUT      = w_tx;
  assign Ser_En      = r_state == DATA;
  assign Ready       = r_state == IDLE || r_state == STOP;
  assign Busy        = r_state != IDLE;
  assign Frame_Err   = r_frame_err;
  assign P_Data_Hold = r_hold;
endmodule
